// File: rtl/sd_spi_pkg.sv
// Shared types and frame constants for the SD-over-SPI command sequencer.
package sd_spi_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      SEND = 3'd2,
      POLL = 3'd3,
      FIN  = 3'd4
   } state_e;

   localparam int         FRAME_BYTES = 6;
   localparam logic [1:0] START_BITS  = 2'b01;
   localparam logic [7:0] IDLE_BYTE   = 8'hFF;

endpackage

// File: rtl/spi_cmd_seq_if.sv
// Host command handshake plus SPI pins of the SD command sequencer.
interface spi_cmd_seq_if;

   logic        start;
   logic [5:0]  cmd_idx;
   logic [31:0] cmd_arg;
   logic [6:0]  cmd_crc;
   logic        busy;
   logic        done;
   logic [7:0]  resp;
   logic        timeout;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;

   modport master (
      output start, cmd_idx, cmd_arg, cmd_crc, miso,
      input  busy, done, resp, timeout, sclk, cs_n, mosi
   );

   modport slave (
      input  start, cmd_idx, cmd_arg, cmd_crc, miso,
      output busy, done, resp, timeout, sclk, cs_n, mosi
   );

endinterface

// File: rtl/sd_sclk_div.sv
// SPI mode-0 clock generator: sclk toggles every CLK_DIV clk while enabled;
// rise/fall strobe the clk cycle whose edge moves sclk high/low.
module sd_sclk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_r;
   logic          sclk_r;
   logic          edge_s;

   assign edge_s = en && (cnt_r == CW'(CLK_DIV - 1));

   // Half-period counter; disabling parks sclk low with the phase reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= '0;
         sclk_r <= 1'b0;
      end else if (!en) begin
         cnt_r  <= '0;
         sclk_r <= 1'b0;
      end else if (edge_s) begin
         cnt_r  <= '0;
         sclk_r <= ~sclk_r;
      end else begin
         cnt_r  <= cnt_r + CW'(1);
      end
   end

   assign sclk = sclk_r;
   assign rise = edge_s & ~sclk_r;
   assign fall = edge_s & sclk_r;

endmodule

// File: rtl/spi_cmd_seq.sv
// SD SPI-mode command frame sequencer: 0xFF preamble, 6-byte command, R1 poll.
// Optional SD_CMD_CRC_GEN_EN computes CRC7 internally instead of using cmd_crc.
module spi_cmd_seq
   import sd_spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int MAX_POLL = 8
) (
   input logic          clk,
   input logic          rst_n,
   spi_cmd_seq_if.slave bus
);

   state_e      state_r;
   logic [5:0]  idx_r;
   logic [31:0] arg_r;
   logic [6:0]  crc_r;
   logic [7:0]  tx_r;
   logic [7:0]  rx_r;
   logic [2:0]  bit_cnt_r;
   logic [7:0]  byte_cnt_r;
   logic        busy_r, done_r, cs_n_r, mosi_r, timeout_r;
   logic [7:0]  resp_r;
   logic [7:0]  sel_s;
   logic [7:0]  next_byte_s;
   logic        en_s, sclk_s, rise_s, fall_s;

`ifdef SD_CMD_CRC_GEN_EN
   function automatic logic [6:0] crc7(input logic [39:0] data);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = data[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction
`endif

   assign en_s = (state_r == PRE) || (state_r == SEND) || (state_r == POLL);

   sd_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en_s),
      .sclk (sclk_s),
      .rise (rise_s),
      .fall (fall_s)
   );

   // Byte to load at the next byte boundary: frame byte 0 after PRE, else the following one.
   always_comb begin
      sel_s       = (state_r == PRE) ? 8'd0 : (byte_cnt_r + 8'd1);
      next_byte_s = IDLE_BYTE;
      case (sel_s)
         8'd0:    next_byte_s = {START_BITS, idx_r};
         8'd1:    next_byte_s = arg_r[31:24];
         8'd2:    next_byte_s = arg_r[23:16];
         8'd3:    next_byte_s = arg_r[15:8];
         8'd4:    next_byte_s = arg_r[7:0];
         8'd5:    next_byte_s = {crc_r, 1'b1};
         default: next_byte_s = IDLE_BYTE;
      endcase
   end

   // Frame FSM with shift datapath; all outputs registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         idx_r      <= 6'd0;
         arg_r      <= 32'd0;
         crc_r      <= 7'd0;
         tx_r       <= IDLE_BYTE;
         rx_r       <= 8'd0;
         bit_cnt_r  <= 3'd0;
         byte_cnt_r <= 8'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         cs_n_r     <= 1'b1;
         mosi_r     <= 1'b1;
         timeout_r  <= 1'b0;
         resp_r     <= 8'hFF;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               mosi_r <= 1'b1;
               if (bus.start) begin
                  idx_r      <= bus.cmd_idx;
                  arg_r      <= bus.cmd_arg;
`ifdef SD_CMD_CRC_GEN_EN
                  crc_r      <= crc7({START_BITS, bus.cmd_idx, bus.cmd_arg});
`else
                  crc_r      <= bus.cmd_crc;
`endif
                  state_r    <= PRE;
                  busy_r     <= 1'b1;
                  cs_n_r     <= 1'b0;
                  timeout_r  <= 1'b0;
                  tx_r       <= IDLE_BYTE;
                  mosi_r     <= IDLE_BYTE[7];
                  bit_cnt_r  <= 3'd0;
                  byte_cnt_r <= 8'd0;
               end
            end
            PRE, SEND, POLL: begin
               if (rise_s) begin
                  rx_r <= {rx_r[6:0], bus.miso};
               end
               if (fall_s) begin
                  if (bit_cnt_r != 3'd7) begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                     tx_r      <= {tx_r[6:0], 1'b1};
                     mosi_r    <= tx_r[6];
                  end else begin
                     bit_cnt_r <= 3'd0;
                     if (state_r == PRE) begin
                        state_r    <= SEND;
                        byte_cnt_r <= 8'd0;
                        tx_r       <= next_byte_s;
                        mosi_r     <= next_byte_s[7];
                     end else if (state_r == SEND && byte_cnt_r == 8'(FRAME_BYTES - 1)) begin
                        state_r    <= POLL;
                        byte_cnt_r <= 8'd0;
                        tx_r       <= IDLE_BYTE;
                        mosi_r     <= IDLE_BYTE[7];
                     end else if (state_r == SEND) begin
                        byte_cnt_r <= byte_cnt_r + 8'd1;
                        tx_r       <= next_byte_s;
                        mosi_r     <= next_byte_s[7];
                     end else if (!rx_r[7] || byte_cnt_r == 8'(MAX_POLL - 1)) begin
                        // R1 responses start with a 0 bit; anything else is still bus idle.
                        state_r    <= FIN;
                        resp_r     <= rx_r[7] ? IDLE_BYTE : rx_r;
                        timeout_r  <= rx_r[7];
                        byte_cnt_r <= 8'd0;
                        busy_r     <= 1'b0;
                        cs_n_r     <= 1'b1;
                        done_r     <= 1'b1;
                        mosi_r     <= 1'b1;
                     end else begin
                        byte_cnt_r <= byte_cnt_r + 8'd1;
                        tx_r       <= IDLE_BYTE;
                        mosi_r     <= IDLE_BYTE[7];
                     end
                  end
               end
            end
            FIN: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               cs_n_r  <= 1'b1;
               mosi_r  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.resp    = resp_r;
   assign bus.timeout = timeout_r;
   assign bus.sclk    = sclk_s;
   assign bus.cs_n    = cs_n_r;
   assign bus.mosi    = mosi_r;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed bench for spi_cmd_seq: SPI slave model on the pins, scoreboard of
// expected MOSI bytes and R1 results. Works with or without SD_CMD_CRC_GEN_EN.
module tb_spi_cmd_seq;

   localparam int CLK_DIV   = 4;
   localparam int MAX_POLL  = 8;
   localparam int BYTE_CLKS = 16 * CLK_DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_cmd_seq_if bus ();

   spi_cmd_seq #(.CLK_DIV(CLK_DIV), .MAX_POLL(MAX_POLL)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int         checks   = 0;
   int         errors   = 0;
   int         done_cnt = 0;
   int         rx_bits  = 0;
   logic       sclk_prev = 1'b0;
   logic [7:0] cur      = 8'h00;
   logic [7:0] mosi_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] miso_bytes[$];
   logic [7:0] exp_resp_q[$];
   logic       exp_to_q[$];

   always @(posedge clk) begin
      if (bus.done) done_cnt++;
   end

   // SPI slave: capture MOSI on sclk rise, present MISO bits on cs_n fall / sclk fall.
   always @(negedge bus.cs_n or posedge bus.sclk or negedge bus.sclk) begin
      logic [7:0] b;
      int         k;
      if (bus.cs_n) begin
         bus.miso = 1'b1;
      end else if (bus.sclk && !sclk_prev) begin
         cur = {cur[6:0], bus.mosi};
         rx_bits++;
         if (rx_bits % 8 == 0) mosi_q.push_back(cur);
      end else begin
         if (!bus.sclk && !sclk_prev) rx_bits = 0;
         k = rx_bits / 8;
         if (k < miso_bytes.size()) begin
            b        = miso_bytes[k];
            bus.miso = b[7 - (rx_bits % 8)];
         end else begin
            bus.miso = 1'b1;
         end
      end
      sclk_prev = bus.sclk;
   end

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc_in,
                           input logic [7:0] crc_byte, input int n_ff, input bit has_resp,
                           input logic [7:0] rbyte, input bit poke);
      int         polls, cyc, d0;
      logic [7:0] e, o;
      logic [7:0] e_resp;
      logic       e_to;
      if (has_resp && (n_ff + 1 <= MAX_POLL)) begin
         polls = n_ff + 1; e_resp = rbyte; e_to = 1'b0;
      end else begin
         polls = MAX_POLL; e_resp = 8'hFF; e_to = 1'b1;
      end
      miso_bytes.delete();
      for (int i = 0; i < 7 + n_ff; i++) miso_bytes.push_back(8'hFF);
      if (has_resp) miso_bytes.push_back(rbyte);
      mosi_q.delete();
      exp_q.push_back(8'hFF);
      exp_q.push_back({2'b01, idx});
      exp_q.push_back(arg[31:24]);
      exp_q.push_back(arg[23:16]);
      exp_q.push_back(arg[15:8]);
      exp_q.push_back(arg[7:0]);
      exp_q.push_back(crc_byte);
      for (int i = 0; i < polls; i++) exp_q.push_back(8'hFF);
      exp_resp_q.push_back(e_resp);
      exp_to_q.push_back(e_to);
      d0 = done_cnt;

      @(negedge clk);
      bus.cmd_idx = idx;
      bus.cmd_arg = arg;
      bus.cmd_crc = crc_in;
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_on_accept", bus.busy, 1'b1);
      check("cs_n_on_accept", bus.cs_n, 1'b0);
      check("timeout_cleared", bus.timeout, 1'b0);

      cyc = 0;
      while (cyc < 20000 && !bus.done) begin
         @(posedge clk); #1;
         cyc++;
         if (poke && cyc == 3 * BYTE_CLKS + 8) begin
            bus.start   = 1'b1;
            bus.cmd_idx = 6'h3F;
            bus.cmd_arg = 32'hDEADBEEF;
            bus.cmd_crc = 7'h11;
         end else begin
            bus.start = 1'b0;
         end
      end
      check("done_seen", bus.done, 1'b1);
      check("frame_clks_in_window",
            (cyc >= (7 + polls) * BYTE_CLKS - 2) && (cyc <= (7 + polls) * BYTE_CLKS + 2), 1'b1);
      check("fin_cs_n", bus.cs_n, 1'b1);
      check("fin_sclk", bus.sclk, 1'b0);
      check("fin_busy", bus.busy, 1'b0);
      check("resp", bus.resp, exp_resp_q.pop_front());
      check("timeout", bus.timeout, exp_to_q.pop_front());
      @(posedge clk); #1;
      check("done_one_cycle", bus.done, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("done_count", done_cnt - d0, 1);
      check("mosi_byte_count", mosi_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'hxx;
         check("mosi_byte", o, e);
      end
   endtask

   initial begin
      int         d0;
      logic [6:0] crc8_in;
`ifdef SD_CMD_CRC_GEN_EN
      crc8_in = 7'h00;
`else
      crc8_in = 7'h43;
`endif
      bus.start   = 1'b0;
      bus.cmd_idx = 6'd0;
      bus.cmd_arg = 32'd0;
      bus.cmd_crc = 7'd0;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sclk", bus.sclk, 1'b0);
      check("rst_cs_n", bus.cs_n, 1'b1);
      check("rst_mosi", bus.mosi, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_timeout", bus.timeout, 1'b0);
      check("rst_resp", bus.resp, 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;

      // CMD0: one idle poll byte, then R1 = 0x01
      do_frame(6'd0, 32'd0, 7'h4A, 8'h95, 1, 1'b1, 8'h01, 1'b0);
      // CMD8 with MISO stuck high: full poll budget then timeout
      do_frame(6'd8, 32'h000001AA, crc8_in, 8'h87, 20, 1'b0, 8'hFF, 1'b0);
      // CMD8 with a stray start in the middle of the command bytes
      do_frame(6'd8, 32'h000001AA, crc8_in, 8'h87, 2, 1'b1, 8'h01, 1'b1);
`ifndef SD_CMD_CRC_GEN_EN
      do_frame(6'd17, 32'h12345678, 7'h55, 8'hAB, 0, 1'b1, 8'h00, 1'b0);
`endif

      // Abort a frame with reset during byte 3
      miso_bytes.delete();
      @(negedge clk);
      bus.cmd_idx = 6'd0;
      bus.cmd_arg = 32'd0;
      bus.cmd_crc = 7'h4A;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3 * BYTE_CLKS + 20) @(posedge clk);
      #1;
      check("pre_abort_busy", bus.busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_sclk", bus.sclk, 1'b0);
      check("abort_cs_n", bus.cs_n, 1'b1);
      check("abort_mosi", bus.mosi, 1'b1);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_resp", bus.resp, 8'hFF);
      check("abort_timeout", bus.timeout, 1'b0);
      d0 = done_cnt;
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - d0, 0);
      mosi_q.delete();
      @(negedge clk);
      rst_n = 1'b1;

      // Clean frame after reset; response lands in the last permitted poll byte
      do_frame(6'd0, 32'd0, 7'h4A, 8'h95, MAX_POLL - 1, 1'b1, 8'h05, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
